// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 host blocks: FSM state encoding, clock
// period and default start-sequence cycle counts.
package dht11_pkg;

  // System clock period (50 kHz).
  localparam int CLK_PERIOD_US = 20;

  // Default start-sequence timing in clocks of CLK_PERIOD_US.
  localparam int DEF_WAIT_CYCLES    = 50000;  // 1 s power-up idle
  localparam int DEF_LOW_CYCLES     = 900;    // 18 ms start pulse
  localparam int DEF_RELEASE_CYCLES = 2;      // 40 us line release

  // Start-sequence FSM states; the encoding is fixed so the receiver and
  // debug tooling can decode it directly.
  typedef logic [1:0] state_t;
  localparam state_t IDLE    = 2'b00;
  localparam state_t LOW     = 2'b01;
  localparam state_t RELEASE = 2'b10;
  localparam state_t DONE    = 2'b11;

endpackage

// File: rtl/start_module.sv
// DHT11 host start sequence: idle after power-up, pull the line low, release
// it briefly, then hand off to the receiver with a level flag.
module start_module
  import dht11_pkg::*;
#(
  parameter int WAIT_CYCLES    = DEF_WAIT_CYCLES,
  parameter int LOW_CYCLES     = DEF_LOW_CYCLES,
  parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES,
  parameter int CNT_W          = 17
) (
  input  logic clk,
  input  logic rst,
  output logic out_delay,
  output logic confirm_to_reciver
);

  // Zero-length phases are not supported and every terminal count must fit.
  if (WAIT_CYCLES < 1 || LOW_CYCLES < 1 || RELEASE_CYCLES < 1) begin : g_bad_len
    $error("start_module: cycle parameters must be >= 1");
  end
  if (longint'(WAIT_CYCLES - 1)    >= (longint'(1) << CNT_W) ||
      longint'(LOW_CYCLES - 1)     >= (longint'(1) << CNT_W) ||
      longint'(RELEASE_CYCLES - 1) >= (longint'(1) << CNT_W)) begin : g_bad_w
    $error("start_module: CNT_W too small for cycle parameters");
  end

  localparam logic [CNT_W-1:0] WAIT_LAST    = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LAST     = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);

  state_t           states, states_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             out_delay_d, confirm_d;

  // Next-state: each timed phase counts up to its last cycle, then the
  // counter restarts and the registered outputs move with the state.
  always_comb begin
    states_d    = states;
    cnt_d       = cnt + 1'b1;
    out_delay_d = out_delay;
    confirm_d   = confirm_to_reciver;
    case (states)
      IDLE: begin
        if (cnt == WAIT_LAST) begin
          cnt_d       = '0;
          states_d    = LOW;
          out_delay_d = 1'b0;
        end
      end
      LOW: begin
        if (cnt == LOW_LAST) begin
          cnt_d       = '0;
          states_d    = RELEASE;
          out_delay_d = 1'b1;
        end
      end
      RELEASE: begin
        if (cnt == RELEASE_LAST) begin
          cnt_d     = '0;
          states_d  = DONE;
          confirm_d = 1'b1;
        end
      end
      default: begin
        // DONE is terminal until the next reset.
        cnt_d       = '0;
        out_delay_d = 1'b1;
        confirm_d   = 1'b1;
      end
    endcase
  end

  // State, counter and output registers; reset releases the line at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      states             <= IDLE;
      cnt                <= '0;
      out_delay          <= 1'b1;
      confirm_to_reciver <= 1'b0;
    end else begin
      states             <= states_d;
      cnt                <= cnt_d;
      out_delay          <= out_delay_d;
      confirm_to_reciver <= confirm_d;
    end
  end

endmodule

// File: tb/tb_start_module.sv
// Bench for start_module: three instances (two short-timed, one default)
// compared each cycle against a time-since-reset model, with random async
// reset aborts on the short-timed pair.
module tb_start_module;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic rst_s, rst_d;
  logic mon;
  logic od_a, cf_a, od_b, cf_b, od_d, cf_d;
  int   errors = 0;
  int   checks = 0;
  int   t_s, t_d;

  start_module #(.WAIT_CYCLES(3), .LOW_CYCLES(5), .RELEASE_CYCLES(1), .CNT_W(3)) dut_a (
    .clk(gclk), .rst(rst_s), .out_delay(od_a), .confirm_to_reciver(cf_a));
  start_module #(.WAIT_CYCLES(20), .LOW_CYCLES(12), .RELEASE_CYCLES(2), .CNT_W(5)) dut_b (
    .clk(gclk), .rst(rst_s), .out_delay(od_b), .confirm_to_reciver(cf_b));
  start_module dut_d (
    .clk(gclk), .rst(rst_d), .out_delay(od_d), .confirm_to_reciver(cf_d));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected {state, out_delay, confirm} after t rising edges out of reset.
  function automatic logic [3:0] model(input int t, input int w, input int l, input int r);
    if (t < w)              return {2'b00, 1'b1, 1'b0};
    else if (t < w + l)     return {2'b01, 1'b0, 1'b0};
    else if (t < w + l + r) return {2'b10, 1'b1, 1'b0};
    else                    return {2'b11, 1'b1, 1'b1};
  endfunction

  // Elapsed clocks since each reset was last released.
  always @(posedge gclk or posedge rst_s)
    if (rst_s) t_s <= 0; else t_s <= t_s + 1;
  always @(posedge gclk or posedge rst_d)
    if (rst_d) t_d <= 0; else t_d <= t_d + 1;

  // Per-cycle comparison against the model, sampled away from the edge.
  always @(negedge gclk) begin : monitor
    logic [3:0] e;
    if (mon) begin
      e = model(t_s, 3, 5, 1);
      chk("a_state", 32'(dut_a.states), 32'(e[3:2]));
      chk("a_out",   32'(od_a), 32'(e[1]));
      chk("a_conf",  32'(cf_a), 32'(e[0]));
      e = model(t_s, 20, 12, 2);
      chk("b_state", 32'(dut_b.states), 32'(e[3:2]));
      chk("b_out",   32'(od_b), 32'(e[1]));
      chk("b_conf",  32'(cf_b), 32'(e[0]));
      e = model(t_d, 50000, 900, 2);
      chk("d_state", 32'(dut_d.states), 32'(e[3:2]));
      chk("d_out",   32'(od_d), 32'(e[1]));
      chk("d_conf",  32'(cf_d), 32'(e[0]));
    end
  end

  initial begin
    rst_s = 1'b1;
    rst_d = 1'b1;
    mon   = 1'b0;
    #1 mon = 1'b1;
    repeat (10) @(negedge gclk);
    fork
      begin : default_run
        @(negedge gclk) rst_d = 1'b0;
        repeat (51000) @(negedge gclk);
      end
      begin : abort_run
        for (int i = 0; i < 40; i++) begin
          int n;
          @(negedge gclk) rst_s = 1'b0;
          // First pass lands mid-LOW on dut_b and in DONE on dut_a.
          n = (i == 0) ? 25 : int'($urandom_range(1, 45));
          repeat (n) @(posedge gclk);
          #($urandom_range(1, 3));
          rst_s = 1'b1;
          #1;
          chk("async_a_state", 32'(dut_a.states), 32'd0);
          chk("async_a_out",   32'(od_a), 32'd1);
          chk("async_a_conf",  32'(cf_a), 32'd0);
          chk("async_b_state", 32'(dut_b.states), 32'd0);
          chk("async_b_out",   32'(od_b), 32'd1);
          chk("async_b_conf",  32'(cf_b), 32'd0);
          repeat ($urandom_range(1, 3)) @(negedge gclk);
        end
        @(negedge gclk) rst_s = 1'b0;
        repeat (60) @(negedge gclk);
      end
    join
    mon = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
